lfsr64_checker: RTL and testbench



---
 rtl/lfsr64_checker_if.sv | 34 +++
 rtl/lfsr64_checker.sv | 151 +++++++++++++++
 tb/tb_lfsr64_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr64_checker_if.sv
// lfsr64_checker_if
//   Bundles the receive-stream beat signals and the checker status outputs.
//   master : stream source / status consumer (drives in_valid, in_bit, clr_counts)
//   slave  : the checker (drives locked, err_pulse, err_count, bit_count, state_out)
//   in_valid   - in_bit is a valid beat this cycle
//   in_bit     - received stream bit
//   clr_counts - clear err_count and bit_count
//   locked     - checker is in LOCKED
//   err_pulse  - one-cycle pulse per mismatched LOCKED beat
//   err_count  - saturating error count
//   bit_count  - saturating count of beats checked while LOCKED
//   state_out  - local LFSR register
interface lfsr64_checker_if #(
   parameter int CNT_W = 32
) ();
   logic             in_valid;
   logic             in_bit;
   logic             clr_counts;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;
   logic [63:0]      state_out;

   modport master (
      output in_valid, in_bit, clr_counts,
      input  locked, err_pulse, err_count, bit_count, state_out
   );

   modport slave (
      input  in_valid, in_bit, clr_counts,
      output locked, err_pulse, err_count, bit_count, state_out
   );
endinterface

// File: rtl/lfsr64_checker.sv
// lfsr64_checker
//   Receive-side checker for the 64-bit Fibonacci xnor LFSR stream
//   (taps 64/63/61/60). Fills a local register from the stream, verifies the
//   prediction for VERIFY_LEN beats, then flywheels its own prediction and
//   counts mismatches. LOSS_THRESH errors inside one WINDOW-beat window drop
//   it back to HUNT.
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - lfsr64_checker_if.slave (stream beats in, lock/error status out)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   HUNT   | shifting received bits in until 64 have been loaded
//   VERIFY | still shifting received bits, counting consecutive matches
//   LOCKED | flywheeling own prediction, counting beats and errors
module lfsr64_checker #(
   parameter int VERIFY_LEN  = 64,
   parameter int WINDOW      = 256,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 32
) (
   input logic clk,
   input logic reset,
   lfsr64_checker_if.slave bus
);

   localparam int VCNT_W = $clog2(VERIFY_LEN + 1);
   localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int WERR_W = $clog2(LOSS_THRESH + 1);

   localparam logic [6:0]        FILL_LAST = 7'd63;
   localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(VERIFY_LEN - 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] WERR_LOSS = WERR_W'(LOSS_THRESH);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_VERIFY = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t           state;
   logic [63:0]      sh;
   logic [6:0]       fill;
   logic [VCNT_W-1:0] vcnt;
   logic [WCNT_W-1:0] wcnt;
   logic [WERR_W-1:0] werr;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;

   logic             in_valid;
   logic             in_bit;
   logic             clr_counts;
   logic             pred;
   logic             mismatch;
   logic [WERR_W-1:0] werr_inc;

   assign in_valid   = bus.in_valid;
   assign in_bit     = bus.in_bit;
   assign clr_counts = bus.clr_counts;

   assign pred     = ~(sh[63] ^ sh[62] ^ sh[60] ^ sh[59]);
   assign mismatch = (in_bit != pred);
   assign werr_inc = werr + WERR_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HUNT;
         sh        <= '0;
         fill      <= '0;
         vcnt      <= '0;
         wcnt      <= '0;
         werr      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (in_valid) begin
            case (state)
               S_HUNT: begin
                  sh <= {sh[62:0], in_bit};
                  if (fill == FILL_LAST) begin
                     state <= S_VERIFY;
                     fill  <= '0;
                     vcnt  <= '0;
                  end else begin
                     fill <= fill + 7'd1;
                  end
               end
               S_VERIFY: begin
                  // received bit goes in regardless of match so a bad fill
                  // is flushed out and the register resynchronises
                  sh <= {sh[62:0], in_bit};
                  if (mismatch) begin
                     vcnt <= '0;
                  end else if (vcnt == VCNT_LAST) begin
                     state  <= S_LOCKED;
                     locked <= 1'b1;
                     wcnt   <= '0;
                     werr   <= '0;
                  end else begin
                     vcnt <= vcnt + VCNT_W'(1);
                  end
               end
               S_LOCKED: begin
                  // flywheel: a corrupted received bit never enters sh
                  sh <= {sh[62:0], pred};
                  if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
                  if (mismatch) begin
                     err_pulse <= 1'b1;
                     if (err_count != '1) err_count <= err_count + CNT_W'(1);
                  end
                  // loss of lock takes priority over the window wrap
                  if (mismatch && (werr_inc == WERR_LOSS)) begin
                     state  <= S_HUNT;
                     locked <= 1'b0;
                     fill   <= '0;
                     werr   <= werr_inc;
                  end else if (wcnt == WCNT_LAST) begin
                     wcnt <= '0;
                     werr <= '0;
                  end else begin
                     wcnt <= wcnt + WCNT_W'(1);
                     if (mismatch) werr <= werr_inc;
                  end
               end
               default: begin
                  state  <= S_HUNT;
                  locked <= 1'b0;
                  fill   <= '0;
               end
            endcase
         end
         if (clr_counts) begin
            err_count <= '0;
            bit_count <= '0;
         end
      end
   end

   assign bus.locked    = locked;
   assign bus.err_pulse = err_pulse;
   assign bus.err_count = err_count;
   assign bus.bit_count = bit_count;
   assign bus.state_out = sh;

endmodule

// File: tb/tb_lfsr64_checker.sv
// tb_lfsr64_checker
//   Drives the checker from a generator model and compares every cycle
//   against a history-queue reference model, plus targeted scenario checks.
module tb_lfsr64_checker;
   localparam int CNT_W = 32;
   localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lfsr64_checker_if #(.CNT_W(CNT_W)) bus ();

   lfsr64_checker #(
      .VERIFY_LEN (64),
      .WINDOW     (256),
      .LOSS_THRESH(8),
      .CNT_W      (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // transmitter
   logic [63:0] gen_s;

   // reference model: the last 64 bits that entered the checker, oldest first
   bit          hist[$];
   int          m_phase;      // 0 hunt, 1 verify, 2 locked
   int          m_fill, m_vcnt, m_wb, m_werr;
   logic [31:0] m_err, m_bits;
   bit          m_pulse;

   int vbeats;
   int pulses;

   function automatic logic [63:0] model_sh();
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = hist[63-i];
      return r;
   endfunction

   function automatic bit model_pred();
      return ~(hist[0] ^ hist[1] ^ hist[3] ^ hist[4]);
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 64; i++) hist.push_back(1'b0);
      m_phase = 0; m_fill = 0; m_vcnt = 0; m_wb = 0; m_werr = 0;
      m_err = '0; m_bits = '0; m_pulse = 1'b0;
   endtask

   task automatic push_hist(input bit x);
      hist.push_back(x);
      void'(hist.pop_front());
   endtask

   task automatic model_step(input bit v, input bit b, input bit clr);
      bit p;
      m_pulse = 1'b0;
      if (v) begin
         p = model_pred();
         if (m_phase == 0) begin
            push_hist(b);
            m_fill++;
            if (m_fill == 64) begin m_phase = 1; m_vcnt = 0; end
         end else if (m_phase == 1) begin
            push_hist(b);
            if (b == p) begin
               m_vcnt++;
               if (m_vcnt == 64) begin m_phase = 2; m_wb = 0; m_werr = 0; end
            end else begin
               m_vcnt = 0;
            end
         end else begin
            push_hist(p);
            if (m_bits != 32'hFFFF_FFFF) m_bits++;
            if (b != p) begin
               if (m_err != 32'hFFFF_FFFF) m_err++;
               m_pulse = 1'b1;
               m_werr++;
            end
            m_wb++;
            if (m_werr == 8) begin
               m_phase = 0; m_fill = 0;
            end else if (m_wb == 256) begin
               m_wb = 0; m_werr = 0;
            end
         end
      end
      if (clr) begin m_err = '0; m_bits = '0; end
   endtask

   task automatic cyc(input bit v, input bit flip, input bit clr);
      bit b, fb;
      if (v) begin
         fb    = ~(gen_s[63] ^ gen_s[62] ^ gen_s[60] ^ gen_s[59]);
         gen_s = {gen_s[62:0], fb};
         b     = fb ^ flip;
         vbeats++;
      end else begin
         b = 1'($urandom);
      end
      bus.in_valid   = v;
      bus.in_bit     = b;
      bus.clr_counts = clr;
      model_step(v, b, clr);
      @(posedge clk);
      #1;
      chk_val("locked",    {63'd0, bus.locked},    {63'd0, (m_phase == 2)});
      chk_val("err_pulse", {63'd0, bus.err_pulse}, {63'd0, m_pulse});
      chk_val("err_count", {32'd0, bus.err_count}, {32'd0, m_err});
      chk_val("bit_count", {32'd0, bus.bit_count}, {32'd0, m_bits});
      chk_val("state_out", bus.state_out, model_sh());
      if (bus.err_pulse) pulses++;
   endtask

   task automatic do_reset(input bit reseed);
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clr_counts = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      vbeats = 0;
      pulses = 0;
      if (reseed) gen_s = SEED;
      chk_val("rst_locked",    {63'd0, bus.locked},    64'd0);
      chk_val("rst_err_pulse", {63'd0, bus.err_pulse}, 64'd0);
      chk_val("rst_err_count", {32'd0, bus.err_count}, 64'd0);
      chk_val("rst_bit_count", {32'd0, bus.bit_count}, 64'd0);
      chk_val("rst_state_out", bus.state_out,          64'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clr_counts = 1'b0;
      gen_s = SEED;
      model_reset();

      // clean stream, lock timing and steady-state counts
      do_reset(1'b1);
      for (int k = 1; k <= 1000; k++) begin
         cyc(1'b1, 1'b0, 1'b0);
         if (k == 127) chk_val("A_lock_b127", {63'd0, bus.locked}, 64'd0);
         if (k == 128) chk_val("A_lock_b128", {63'd0, bus.locked}, 64'd1);
      end
      chk_val("A_err",   {32'd0, bus.err_count}, 64'd0);
      chk_val("A_bits",  {32'd0, bus.bit_count}, 64'd872);
      chk_val("A_state", bus.state_out, gen_s);

      // single flipped bit while locked
      do_reset(1'b1);
      for (int k = 1; k <= 500; k++) cyc(1'b1, (k == 300), 1'b0);
      chk_val("B_pulses", 64'(pulses), 64'd1);
      chk_val("B_err",    {32'd0, bus.err_count}, 64'd1);
      chk_val("B_locked", {63'd0, bus.locked}, 64'd1);
      chk_val("B_state",  bus.state_out, gen_s);

      // 8 errors in one window: loss of lock, then relock 128 beats later
      do_reset(1'b1);
      for (int k = 1; k <= 700; k++) begin
         cyc(1'b1, (k >= 400 && k <= 414 && (k % 2 == 0)), 1'b0);
         if (k == 413) chk_val("C_lock_b413", {63'd0, bus.locked}, 64'd1);
         if (k == 414) begin
            chk_val("C_lock_b414", {63'd0, bus.locked}, 64'd0);
            chk_val("C_err_b414",  {32'd0, bus.err_count}, 64'd8);
         end
         if (k == 541) chk_val("C_relock_b541", {63'd0, bus.locked}, 64'd0);
         if (k == 542) chk_val("C_relock_b542", {63'd0, bus.locked}, 64'd1);
      end
      chk_val("C_pulses", 64'(pulses), 64'd8);

      // valid every third cycle, random in_bit on idle cycles
      do_reset(1'b1);
      for (int c = 0; c < 1000 && vbeats < 140; c++) begin
         cyc((c % 3 == 2), 1'b0, 1'b0);
         chk_val("D_lock", {63'd0, bus.locked}, {63'd0, (vbeats >= 128)});
      end
      chk_val("D_vbeats", 64'(vbeats), 64'd140);

      // clear coinciding with an error beat
      do_reset(1'b1);
      for (int k = 1; k <= 200; k++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk_val("E_clr_err",   {32'd0, bus.err_count}, 64'd0);
      chk_val("E_clr_bits",  {32'd0, bus.bit_count}, 64'd0);
      chk_val("E_clr_pulse", {63'd0, bus.err_pulse}, 64'd1);
      for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk_val("E_err_next",  {32'd0, bus.err_count}, 64'd1);
      chk_val("E_bits_next", {32'd0, bus.bit_count}, 64'd11);

      // reset in VERIFY, resume the stream
      do_reset(1'b1);
      for (int k = 1; k <= 100; k++) cyc(1'b1, 1'b0, 1'b0);
      do_reset(1'b0);
      for (int k = 1; k <= 130; k++) begin
         cyc(1'b1, 1'b0, 1'b0);
         if (k == 127) chk_val("F_lock_b127", {63'd0, bus.locked}, 64'd0);
         if (k == 128) chk_val("F_lock_b128", {63'd0, bus.locked}, 64'd1);
      end

      // errors straddling a window wrap: 7 + 7 stays locked, the 8th in window drops
      do_reset(1'b1);
      for (int k = 1; k <= 392; k++) begin
         cyc(1'b1, (k >= 378), 1'b0);
         if (k == 391) chk_val("H_lock_b391", {63'd0, bus.locked}, 64'd1);
         if (k == 392) chk_val("H_lock_b392", {63'd0, bus.locked}, 64'd0);
      end
      chk_val("H_err", {32'd0, bus.err_count}, 64'd15);

      // randomized traffic: gaps, sparse bit flips, occasional clears
      do_reset(1'b1);
      for (int c = 0; c < 3000; c++) begin
         bit v, f, cl;
         v  = ($urandom_range(0, 9) < 7);
         f  = v && ($urandom_range(0, 47) == 0);
         cl = ($urandom_range(0, 199) == 0);
         cyc(v, f, cl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
